uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: two-flop synchronised RX, mid-bit sampling,
// optional parity, one or two stop bits, break handling and a host handshake.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 2604,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BREAK = 3'd5;

    logic                 sync_q, sync_d;
    logic                 rxs_q, rxs_d;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 rdy_q, rdy_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic sample;
    logic complete;
    logic stop_now;

    assign sample = (baud_q == '0);

    always_comb begin
        sync_d     = RX;
        rxs_d      = sync_q;
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        rdy_d      = rdy_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        complete   = 1'b0;
        // Sticky over all stop bits, including the one being sampled now.
        stop_now   = stop_bad_q | ~rxs_q;

        if (state_q != IDLE && state_q != BREAK) begin
            baud_d = sample ? FULL_LOAD : baud_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    baud_d  = HALF_LOAD;
                end
            end
            START: begin
                if (sample) begin
                    bit_d      = '0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                    state_d    = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                if (sample) begin
                    par_bad_d = (PARITY == 1) ? ~(^shift_q ^ rxs_q) : (^shift_q ^ rxs_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (bit_q == LAST_STOP) begin
                        complete = 1'b1;
                        bit_d    = '0;
                        state_d  = (stop_now && !rxs_q) ? BREAK : IDLE;
                    end else begin
                        bit_d      = bit_q + BIT_W'(1);
                        stop_bad_d = stop_now;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing frame outranks a simultaneous acknowledge.
        if (complete) begin
            rdy_d  = 1'b1;
            data_d = shift_q;
            perr_d = (PARITY != 0) && par_bad_q;
            ferr_d = stop_now;
            ovr_d  = rdy_q && !clr_rdy;
        end else if (clr_rdy) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            rdy_q      <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rxs_q      <= rxs_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rdy        = rdy_q;
    assign rx_data    = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
